mcpu_core_counted_scoreboard: RTL and testbench

Parametrised successor to the core's single-bit register/predicate scoreboard. It tracks outstanding writes per GPR and per predicate with saturating counters instead of busy bits. This lets several in-flight producers target the same destination, for example variable-latency memory ops overlapping ALU ops. It sits between decode (issue side) and writeback, supplies busy/full vectors to decode's hazard check, and adds pipeline flush, drain detection and sticky error reporting.

---
 rtl/mcpu_core_counted_scoreboard_if.sv | 37 +++
 rtl/mcpu_core_counted_scoreboard.sv | 108 ++++++++++
 tb/tb_mcpu_core_counted_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_counted_scoreboard_if.sv
// Issue/writeback bundle between decode, writeback and the counted scoreboard.
// The master side drives the issue and retire lanes; the slave side returns hazard state.
interface mcpu_core_counted_scoreboard_if #(
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NPREDS  = 3,
   parameter int unsigned ISSUE_W = 4,
   parameter int unsigned WB_W    = 4,
   parameter int unsigned RW      = $clog2(NREGS)
);
   logic [ISSUE_W*RW-1:0] iss_rd_num;
   logic [ISSUE_W-1:0]    iss_rd_we;
   logic [ISSUE_W-1:0]    iss_pred_we;
   logic                  iss_progress;
   logic [WB_W*RW-1:0]    wb_rd_num;
   logic [WB_W-1:0]       wb_rd_we;
   logic [WB_W-1:0]       wb_pred_we;
   logic                  flush;
   logic                  err_clr;
   logic [NREGS-1:0]      sb_reg_busy;
   logic [NREGS-1:0]      sb_reg_full;
   logic [NPREDS-1:0]     sb_pred_busy;
   logic [NPREDS-1:0]     sb_pred_full;
   logic                  sb_drained;
   logic [1:0]            sb_err;

   modport master (
      output iss_rd_num, iss_rd_we, iss_pred_we, iss_progress,
      output wb_rd_num, wb_rd_we, wb_pred_we, flush, err_clr,
      input  sb_reg_busy, sb_reg_full, sb_pred_busy, sb_pred_full, sb_drained, sb_err
   );

   modport slave (
      input  iss_rd_num, iss_rd_we, iss_pred_we, iss_progress,
      input  wb_rd_num, wb_rd_we, wb_pred_we, flush, err_clr,
      output sb_reg_busy, sb_reg_full, sb_pred_busy, sb_pred_full, sb_drained, sb_err
   );
endinterface

// File: rtl/mcpu_core_counted_scoreboard.sv
// Counted register/predicate scoreboard: saturating outstanding-write counters per
// destination, with flush, drain detection and sticky overflow/underflow reporting.
module mcpu_core_counted_scoreboard #(
   parameter int unsigned NREGS     = 32,
   parameter int unsigned NPREDS    = 3,
   parameter int unsigned ISSUE_W   = 4,
   parameter int unsigned WB_W      = 4,
   parameter int unsigned CNT_W     = 2,
   parameter bit          REG0_ZERO = 1'b1
) (
   input logic                           clkrst_core_clk,
   input logic                           clkrst_core_rst,
   mcpu_core_counted_scoreboard_if.slave sb
);
   localparam int unsigned RW = $clog2(NREGS);
   localparam int unsigned SW = CNT_W + $clog2(ISSUE_W + WB_W) + 1;
   localparam logic [CNT_W-1:0]     CMAX   = '1;
   localparam logic signed [SW-1:0] ONE    = SW'(1);
   localparam logic signed [SW-1:0] CMAX_S = SW'(CMAX);

   logic [CNT_W-1:0] count_q  [NREGS];
   logic [CNT_W-1:0] count_d  [NREGS];
   logic [CNT_W-1:0] pcount_q [NPREDS];
   logic [CNT_W-1:0] pcount_d [NPREDS];
   logic [1:0]       err_q, err_d;

   // Returns {underflow, overflow, clamped count}.
   function automatic logic [CNT_W+1:0] step(input logic [CNT_W-1:0] cnt,
                                             input logic [ISSUE_W-1:0] ih,
                                             input logic [WB_W-1:0] dh);
      logic signed [SW-1:0] nxt;
      nxt = $signed(SW'(cnt));
      for (int i = 0; i < ISSUE_W; i++) if (ih[i]) nxt = nxt + ONE;
      for (int j = 0; j < WB_W; j++) if (dh[j]) nxt = nxt - ONE;
      if (nxt[SW-1])           return {2'b10, {CNT_W{1'b0}}};
      else if (nxt > CMAX_S)   return {2'b01, CMAX};
      else                     return {2'b00, nxt[CNT_W-1:0]};
   endfunction

   always_comb begin
      logic [ISSUE_W-1:0] ih;
      logic [WB_W-1:0]    dh;
      logic [CNT_W+1:0]   res;
      logic [1:0]         ev;
      ih  = '0;
      dh  = '0;
      res = '0;
      ev  = '0;
      for (int r = 0; r < NREGS; r++) begin
         for (int i = 0; i < ISSUE_W; i++)
            ih[i] = sb.iss_progress & sb.iss_rd_we[i] & (sb.iss_rd_num[i*RW +: RW] == RW'(r));
         for (int j = 0; j < WB_W; j++)
            dh[j] = sb.wb_rd_we[j] & (sb.wb_rd_num[j*RW +: RW] == RW'(r));
         if (REG0_ZERO && r == 0) begin
            ih = '0;
            dh = '0;
         end
         res        = step(count_q[r], ih, dh);
         count_d[r] = res[CNT_W-1:0];
         ev         = ev | res[CNT_W+1:CNT_W];
      end
      // Predicate indices at or above NPREDS simply never match.
      for (int p = 0; p < NPREDS; p++) begin
         for (int i = 0; i < ISSUE_W; i++)
            ih[i] = sb.iss_progress & sb.iss_pred_we[i] & (sb.iss_rd_num[i*RW +: RW] == RW'(p));
         for (int j = 0; j < WB_W; j++)
            dh[j] = sb.wb_pred_we[j] & (sb.wb_rd_num[j*RW +: RW] == RW'(p));
         res         = step(pcount_q[p], ih, dh);
         pcount_d[p] = res[CNT_W-1:0];
         ev          = ev | res[CNT_W+1:CNT_W];
      end
      if (sb.flush) begin
         for (int r = 0; r < NREGS; r++) count_d[r] = '0;
         for (int p = 0; p < NPREDS; p++) pcount_d[p] = '0;
         ev = '0;
      end
      err_d = (sb.err_clr ? 2'b00 : err_q) | ev;
   end

   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         for (int r = 0; r < NREGS; r++) count_q[r] <= '0;
         for (int p = 0; p < NPREDS; p++) pcount_q[p] <= '0;
         err_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) count_q[r] <= count_d[r];
         for (int p = 0; p < NPREDS; p++) pcount_q[p] <= pcount_d[p];
         err_q <= err_d;
      end
   end

   always_comb begin
      logic any;
      any = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         sb.sb_reg_busy[r] = |count_q[r];
         sb.sb_reg_full[r] = &count_q[r];
         any               = any | (|count_q[r]);
      end
      for (int p = 0; p < NPREDS; p++) begin
         sb.sb_pred_busy[p] = |pcount_q[p];
         sb.sb_pred_full[p] = &pcount_q[p];
         any                = any | (|pcount_q[p]);
      end
      sb.sb_drained = ~any;
      sb.sb_err     = err_q;
   end
endmodule

// File: tb/tb_mcpu_core_counted_scoreboard.sv
// Bench for the counted scoreboard: directed scenarios plus randomized traffic,
// all compared against an arithmetic model of outstanding writes.
module tb_mcpu_core_counted_scoreboard;
   localparam int NREGS = 32, NPREDS = 3, ISSUE_W = 4, WB_W = 4, CNT_W = 2;
   localparam int RW = 5, CMAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int         m_cnt  [NREGS];
   int         m_pcnt [NPREDS];
   logic [1:0] m_err;

   mcpu_core_counted_scoreboard_if #(.NREGS(NREGS), .NPREDS(NPREDS), .ISSUE_W(ISSUE_W),
                                     .WB_W(WB_W), .RW(RW)) sb ();

   mcpu_core_counted_scoreboard #(.NREGS(NREGS), .NPREDS(NPREDS), .ISSUE_W(ISSUE_W),
                                  .WB_W(WB_W), .CNT_W(CNT_W), .REG0_ZERO(1'b1)) dut (
      .clkrst_core_clk(clk),
      .clkrst_core_rst(rst),
      .sb             (sb.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [NREGS-1:0] e_busy();
      for (int r = 0; r < NREGS; r++) e_busy[r] = (m_cnt[r] != 0);
   endfunction
   function automatic logic [NREGS-1:0] e_full();
      for (int r = 0; r < NREGS; r++) e_full[r] = (m_cnt[r] == CMAX);
   endfunction
   function automatic logic [NPREDS-1:0] e_pbusy();
      for (int p = 0; p < NPREDS; p++) e_pbusy[p] = (m_pcnt[p] != 0);
   endfunction
   function automatic logic [NPREDS-1:0] e_pfull();
      for (int p = 0; p < NPREDS; p++) e_pfull[p] = (m_pcnt[p] == CMAX);
   endfunction
   function automatic logic e_drained();
      e_drained = 1'b1;
      for (int r = 0; r < NREGS; r++) if (m_cnt[r] != 0) e_drained = 1'b0;
      for (int p = 0; p < NPREDS; p++) if (m_pcnt[p] != 0) e_drained = 1'b0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
      for (int p = 0; p < NPREDS; p++) m_pcnt[p] = 0;
      m_err = 2'b00;
   endtask

   // Count outstanding writes as plain integers, then clamp into [0, CMAX].
   task automatic model_step();
      logic [1:0] ev;
      int idx;
      ev = 2'b00;
      if (sb.flush) begin
         for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
         for (int p = 0; p < NPREDS; p++) m_pcnt[p] = 0;
      end else begin
         for (int i = 0; i < ISSUE_W; i++) begin
            idx = int'(sb.iss_rd_num[i*RW +: RW]);
            if (sb.iss_progress && sb.iss_rd_we[i] && idx != 0) m_cnt[idx]++;
            if (sb.iss_progress && sb.iss_pred_we[i] && idx < NPREDS) m_pcnt[idx]++;
         end
         for (int j = 0; j < WB_W; j++) begin
            idx = int'(sb.wb_rd_num[j*RW +: RW]);
            if (sb.wb_rd_we[j] && idx != 0) m_cnt[idx]--;
            if (sb.wb_pred_we[j] && idx < NPREDS) m_pcnt[idx]--;
         end
         for (int r = 0; r < NREGS; r++) begin
            if (m_cnt[r] > CMAX) begin m_cnt[r] = CMAX; ev[0] = 1'b1; end
            if (m_cnt[r] < 0)    begin m_cnt[r] = 0;    ev[1] = 1'b1; end
         end
         for (int p = 0; p < NPREDS; p++) begin
            if (m_pcnt[p] > CMAX) begin m_pcnt[p] = CMAX; ev[0] = 1'b1; end
            if (m_pcnt[p] < 0)    begin m_pcnt[p] = 0;    ev[1] = 1'b1; end
         end
      end
      m_err = (sb.err_clr ? 2'b00 : m_err) | ev;
   endtask

   task automatic clear_inputs();
      sb.iss_rd_num = '0; sb.iss_rd_we = '0; sb.iss_pred_we = '0; sb.iss_progress = 1'b0;
      sb.wb_rd_num = '0; sb.wb_rd_we = '0; sb.wb_pred_we = '0;
      sb.flush = 1'b0; sb.err_clr = 1'b0;
   endtask

   task automatic iss(input int lane, input int num, input bit rwe, input bit pwe);
      sb.iss_rd_num[lane*RW +: RW] = RW'(num);
      sb.iss_rd_we[lane]   = rwe;
      sb.iss_pred_we[lane] = pwe;
      sb.iss_progress      = 1'b1;
   endtask

   task automatic wb(input int lane, input int num, input bit rwe, input bit pwe);
      sb.wb_rd_num[lane*RW +: RW] = RW'(num);
      sb.wb_rd_we[lane]   = rwe;
      sb.wb_pred_we[lane] = pwe;
   endtask

   // One clock: model follows the edge, inputs are cleared, outputs settle by +1.
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (sb.sb_reg_busy !== '0 || sb.sb_reg_full !== '0 || sb.sb_pred_busy !== '0 ||
          sb.sb_pred_full !== '0 || sb.sb_drained !== 1'b1 || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL reset busy=%h full=%h pbusy=%b pfull=%b drained=%b err=%b exp 0/0/0/0/1/00",
                  sb.sb_reg_busy, sb.sb_reg_full, sb.sb_pred_busy, sb.sb_pred_full,
                  sb.sb_drained, sb.sb_err);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      iss(0, 7, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_busy[7] !== 1'b1 || sb.sb_drained !== 1'b0) begin
         errors++;
         $display("FAIL basic_issue busy7=%b drained=%b exp 1 0", sb.sb_reg_busy[7], sb.sb_drained);
      end
      wb(0, 7, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_busy !== e_busy() || sb.sb_drained !== 1'b1) begin
         errors++;
         $display("FAIL basic_wb busy=%h drained=%b exp %h 1", sb.sb_reg_busy, sb.sb_drained, e_busy());
      end
   endtask

   task automatic test_same_cycle();
      iss(0, 9, 1, 0);
      tick();
      iss(1, 9, 1, 0);
      wb(2, 9, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_busy[9] !== 1'b1 || sb.sb_reg_busy !== e_busy()) begin
         errors++;
         $display("FAIL same_cycle busy=%h exp %h", sb.sb_reg_busy, e_busy());
      end
      wb(0, 9, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_busy[9] !== 1'b0 || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL same_cycle_drain busy9=%b err=%b exp 0 00", sb.sb_reg_busy[9], sb.sb_err);
      end
   endtask

   task automatic test_saturate();
      iss(0, 5, 1, 0); iss(1, 5, 1, 0); iss(2, 5, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_full[5] !== 1'b1 || sb.sb_reg_full !== e_full() || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL saturate_full full=%h err=%b exp %h 00", sb.sb_reg_full, sb.sb_err, e_full());
      end
      iss(0, 5, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_full[5] !== 1'b1 || sb.sb_err !== 2'b01) begin
         errors++;
         $display("FAIL saturate_ovf full5=%b err=%b exp 1 01", sb.sb_reg_full[5], sb.sb_err);
      end
      wb(0, 5, 1, 0); wb(1, 5, 1, 0); wb(2, 5, 1, 0);
      sb.err_clr = 1'b1;
      tick();
      checks++;
      if (sb.sb_reg_busy[5] !== 1'b0 || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL saturate_drain busy5=%b err=%b exp 0 00", sb.sb_reg_busy[5], sb.sb_err);
      end
   endtask

   task automatic test_underflow();
      wb(0, 3, 1, 0);
      tick();
      checks++;
      if (sb.sb_err !== 2'b10 || sb.sb_reg_busy[3] !== 1'b0) begin
         errors++;
         $display("FAIL underflow err=%b busy3=%b exp 10 0", sb.sb_err, sb.sb_reg_busy[3]);
      end
      sb.err_clr = 1'b1;
      tick();
      checks++;
      if (sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL err_clr err=%b exp 00", sb.sb_err);
      end
      sb.err_clr = 1'b1;
      wb(1, 3, 1, 0);
      tick();
      checks++;
      if (sb.sb_err !== 2'b10) begin
         errors++;
         $display("FAIL err_clr_vs_event err=%b exp 10", sb.sb_err);
      end
      sb.err_clr = 1'b1;
      iss(0, 0, 1, 0);
      tick();
      checks++;
      if (sb.sb_reg_busy[0] !== 1'b0 || sb.sb_drained !== 1'b1 || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL reg0 busy0=%b drained=%b err=%b exp 0 1 00",
                  sb.sb_reg_busy[0], sb.sb_drained, sb.sb_err);
      end
   endtask

   task automatic test_pred();
      iss(0, 2, 0, 1); iss(1, 5, 0, 1);
      tick();
      checks++;
      if (sb.sb_pred_busy !== 3'b100 || sb.sb_err !== 2'b00 || sb.sb_reg_busy !== '0) begin
         errors++;
         $display("FAIL pred pbusy=%b err=%b busy=%h exp 100 00 0",
                  sb.sb_pred_busy, sb.sb_err, sb.sb_reg_busy);
      end
      wb(3, 2, 0, 1);
      tick();
      checks++;
      if (sb.sb_pred_busy !== 3'b000 || sb.sb_drained !== 1'b1) begin
         errors++;
         $display("FAIL pred_wb pbusy=%b drained=%b exp 000 1", sb.sb_pred_busy, sb.sb_drained);
      end
   endtask

   task automatic test_no_progress();
      iss(0, 1, 1, 0); iss(1, 2, 1, 1);
      sb.iss_progress = 1'b0;
      tick();
      checks++;
      if (sb.sb_reg_busy !== '0 || sb.sb_pred_busy !== '0 || sb.sb_drained !== 1'b1) begin
         errors++;
         $display("FAIL no_progress busy=%h pbusy=%b drained=%b exp 0 0 1",
                  sb.sb_reg_busy, sb.sb_pred_busy, sb.sb_drained);
      end
   endtask

   task automatic test_flush();
      wb(0, 3, 1, 0);
      tick();
      iss(0, 4, 1, 0); iss(1, 10, 1, 0); iss(2, 1, 0, 1);
      tick();
      checks++;
      if (sb.sb_reg_busy !== e_busy() || sb.sb_pred_busy !== 3'b010 || sb.sb_drained !== 1'b0) begin
         errors++;
         $display("FAIL flush_load busy=%h pbusy=%b exp %h 010", sb.sb_reg_busy, sb.sb_pred_busy,
                  e_busy());
      end
      iss(0, 11, 1, 0);
      wb(0, 6, 1, 0);
      sb.flush = 1'b1;
      tick();
      checks++;
      if (sb.sb_reg_busy !== '0 || sb.sb_pred_busy !== '0 || sb.sb_drained !== 1'b1 ||
          sb.sb_err !== 2'b10) begin
         errors++;
         $display("FAIL flush busy=%h pbusy=%b drained=%b err=%b exp 0 0 1 10",
                  sb.sb_reg_busy, sb.sb_pred_busy, sb.sb_drained, sb.sb_err);
      end
      sb.err_clr = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < ISSUE_W; i++)
            iss(i, int'($urandom_range(0, 11)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0));
         sb.iss_progress = ($urandom_range(0, 3) != 0);
         for (int j = 0; j < WB_W; j++)
            wb(j, int'($urandom_range(0, 11)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0));
         sb.flush   = ($urandom_range(0, 29) == 0);
         sb.err_clr = ($urandom_range(0, 7) == 0);
         tick();
         checks++;
         if (sb.sb_reg_busy !== e_busy() || sb.sb_reg_full !== e_full() ||
             sb.sb_pred_busy !== e_pbusy() || sb.sb_pred_full !== e_pfull() ||
             sb.sb_drained !== e_drained() || sb.sb_err !== m_err) begin
            errors++;
            $display("FAIL random[%0d] busy=%h full=%h pb=%b pf=%b dr=%b err=%b exp %h %h %b %b %b %b",
                     n, sb.sb_reg_busy, sb.sb_reg_full, sb.sb_pred_busy, sb.sb_pred_full,
                     sb.sb_drained, sb.sb_err, e_busy(), e_full(), e_pbusy(), e_pfull(),
                     e_drained(), m_err);
         end
      end
   endtask

   task automatic test_async_reset();
      wb(0, 8, 1, 0);
      tick();
      iss(0, 4, 1, 0); iss(1, 4, 1, 0); iss(2, 0, 0, 1);
      tick();
      checks++;
      if (sb.sb_drained !== 1'b0 || sb.sb_err === 2'b00) begin
         errors++;
         $display("FAIL async_preload drained=%b err=%b exp 0 nonzero", sb.sb_drained, sb.sb_err);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (sb.sb_reg_busy !== '0 || sb.sb_reg_full !== '0 || sb.sb_pred_busy !== '0 ||
          sb.sb_drained !== 1'b1 || sb.sb_err !== 2'b00) begin
         errors++;
         $display("FAIL async_reset busy=%h full=%h pbusy=%b drained=%b err=%b exp 0 0 0 1 00",
                  sb.sb_reg_busy, sb.sb_reg_full, sb.sb_pred_busy, sb.sb_drained, sb.sb_err);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_same_cycle();
      test_saturate();
      test_underflow();
      test_pred();
      test_no_progress();
      test_flush();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
